// File: rtl/mod_n_updown_counter_pkg.sv
// Shared direction/mode encodings and width helper for the modulo-N counter family.
// Pure constants and a function; no timing or flow control of its own.
package mod_n_updown_counter_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic int min_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/mod_n_updown_counter_step.sv
// Combinational next-count for one enabled step: +/-1 with wrap or saturate at 0 and MODULUS-1.
// Zero latency, no flow control; the owner decides whether the step is taken.
module mod_n_step
  import mod_n_updown_counter_pkg::*;
#(
  parameter int MODULUS = 12,
  parameter int WIDTH   = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] nxt,
  output logic             wrapped
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] step_x;
  logic           going_down;
  logic           at_limit;

  assign going_down = (up_dn == CNT_DN);

  // Limit is detected from the widened step (borrow out, or one past the top),
  // so a power-of-two modulus still wraps on the explicit compare.
  always_comb begin
    step_x   = going_down ? ({1'b0, cur} - ONE_X) : ({1'b0, cur} + ONE_X);
    at_limit = going_down ? step_x[WIDTH] : (step_x > MAX_X);
    nxt      = cur;
    wrapped  = 1'b0;
    if (!at_limit) begin
      nxt = step_x[WIDTH-1:0];
    end else if (sat_mode == MODE_WRAP) begin
      nxt     = going_down ? MAX_W : '0;
      wrapped = 1'b1;
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clamped parallel load; outputs registered or decoded from the count.
// One-cycle update latency; no backpressure, en gates each step.
module mod_n_updown_counter
  import mod_n_updown_counter_pkg::*;
#(
  parameter int MODULUS   = 12,
  parameter int WIDTH     = $clog2(MODULUS),
  parameter int RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > 65536) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must be in 2..65536");
  end
  if (WIDTH < min_width(MODULUS)) begin : g_bad_width
    $error("mod_n_updown_counter: WIDTH too narrow for MODULUS");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("mod_n_updown_counter: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] step_nxt;
  logic             step_wrapped;
  logic             in_range;

  mod_n_step #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_step (
    .cur      (cnt_q),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .nxt      (step_nxt),
    .wrapped  (step_wrapped)
  );

  assign in_range = ({1'b0, d_in} < MOD_X);

  // Load beats count; an out-of-range load clamps to the top instead of being dropped.
  always_comb begin
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      cnt_d      = in_range ? d_in : MAX_W;
      load_err_d = !in_range;
    end else if (en) begin
      cnt_d  = step_nxt;
      wrap_d = step_wrapped;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= RST_W;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign d_out    = cnt_q;
  assign at_max   = (cnt_q == MAX_W);
  assign at_min   = (cnt_q == '0);
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench: default mod-12 instance plus mod-16 and mod-5 instances (RESET_VAL=2).
module tb_mod_n_updown_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, up_dn = 1'b0, sat_mode = 1'b0, load = 1'b0;
  logic [3:0] d_in = 4'd0;

  logic [3:0] d_out12, d_out16;
  logic [2:0] d_out5;
  logic       at_max12, at_min12, wrap12, err12;
  logic       at_max16, at_min16, wrap16, err16;
  logic       at_max5, at_min5, wrap5, err5;

  int checks = 0;
  int errors = 0;

  int m12, m16, m5;
  bit w12, w16, w5, e12, e16, e5;

  always #5 clock = ~clock;

  mod_n_updown_counter dut12 (
    .clock(clock), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .load(load),
    .d_in(d_in), .d_out(d_out12), .at_max(at_max12), .at_min(at_min12), .wrap(wrap12), .load_err(err12)
  );

  mod_n_updown_counter #(.MODULUS(16), .WIDTH(4), .RESET_VAL(2)) dut16 (
    .clock(clock), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .load(load),
    .d_in(d_in), .d_out(d_out16), .at_max(at_max16), .at_min(at_min16), .wrap(wrap16), .load_err(err16)
  );

  mod_n_updown_counter #(.MODULUS(5), .WIDTH(3), .RESET_VAL(2)) dut5 (
    .clock(clock), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .load(load),
    .d_in(d_in[2:0]), .d_out(d_out5), .at_max(at_max5), .at_min(at_min5), .wrap(wrap5), .load_err(err5)
  );

  // Reference: count as a plain integer and fold back into 0..m-1 with modulo arithmetic.
  function automatic void ref_next(input int m, input int cur, input bit ld, input int din,
                                   input bit e, input bit up, input bit sat,
                                   output int nxt, output bit wr, output bit er);
    int raw;
    nxt = cur; wr = 0; er = 0;
    if (ld) begin
      if (din < m) nxt = din;
      else begin nxt = m - 1; er = 1; end
    end else if (e) begin
      raw = up ? cur + 1 : cur - 1;
      if (raw >= 0 && raw < m) nxt = raw;
      else if (!sat) begin nxt = (raw + m) % m; wr = 1; end
    end
  endfunction

  task automatic tick();
    int n12, n16, n5;
    bit a12, a16, a5, b12, b16, b5;
    ref_next(12, m12, load, int'(d_in), en, up_dn, sat_mode, n12, a12, b12);
    ref_next(16, m16, load, int'(d_in), en, up_dn, sat_mode, n16, a16, b16);
    ref_next(5, m5, load, int'(d_in[2:0]), en, up_dn, sat_mode, n5, a5, b5);
    @(posedge clock);
    if (reset) begin
      m12 = n12; w12 = a12; e12 = b12;
      m16 = n16; w16 = a16; e16 = b16;
      m5  = n5;  w5  = a5;  e5  = b5;
    end
    #1;
  endtask

  task automatic reset_now();
    reset = 1'b0;
    m12 = 0; m16 = 2; m5 = 2;
    w12 = 0; w16 = 0; w5 = 0; e12 = 0; e16 = 0; e5 = 0;
  endtask

  task automatic test_reset();
    reset_now();
    @(posedge clock); #1;
    checks++; if (d_out12 !== 4'd0) begin errors++; $display("FAIL reset_dout got %0d want 0", d_out12); end
    checks++; if (at_min12 !== 1'b1 || at_max12 !== 1'b0) begin errors++; $display("FAIL reset_flags got min=%b max=%b want 1 0", at_min12, at_max12); end
    checks++; if (wrap12 !== 1'b0 || err12 !== 1'b0) begin errors++; $display("FAIL reset_pulses got wrap=%b err=%b want 0 0", wrap12, err12); end
    checks++; if (d_out16 !== 4'd2 || d_out5 !== 3'd2) begin errors++; $display("FAIL reset_val got %0d/%0d want 2/2", d_out16, d_out5); end
    reset = 1'b1;
    load = 1'b1; d_in = 4'd5; tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; tick(); tick();
    checks++; if (d_out12 !== 4'd7) begin errors++; $display("FAIL midcount_dout got %0d want 7", d_out12); end
    #3; reset_now(); #1;
    checks++; if (d_out12 !== 4'd0) begin errors++; $display("FAIL async_reset_dout got %0d want 0", d_out12); end
    checks++; if (wrap12 !== 1'b0 || err12 !== 1'b0) begin errors++; $display("FAIL async_reset_pulses got wrap=%b err=%b want 0 0", wrap12, err12); end
    load = 1'b1; d_in = 4'd9;
    @(posedge clock); #1;
    checks++; if (d_out12 !== 4'd0) begin errors++; $display("FAIL reset_blocks_load got %0d want 0", d_out12); end
    #1; reset = 1'b1; load = 1'b0; en = 1'b0;
    tick();
    checks++; if (d_out12 !== 4'd0 || err12 !== 1'b0) begin errors++; $display("FAIL no_pending_load got %0d err=%b want 0 0", d_out12, err12); end
  endtask

  task automatic test_up_wrap();
    int exp_cnt[3] = '{11, 0, 1};
    bit exp_wrap[3] = '{1'b0, 1'b1, 1'b0};
    bit exp_max[3]  = '{1'b1, 1'b0, 1'b0};
    sat_mode = 1'b0; en = 1'b0; load = 1'b1; d_in = 4'd10; tick();
    checks++; if (d_out12 !== 4'd10) begin errors++; $display("FAIL upwrap_load got %0d want 10", d_out12); end
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (d_out12 !== 4'(exp_cnt[i])) begin errors++; $display("FAIL upwrap_dout[%0d] got %0d want %0d", i, d_out12, exp_cnt[i]); end
      checks++; if (wrap12 !== exp_wrap[i]) begin errors++; $display("FAIL upwrap_wrap[%0d] got %b want %b", i, wrap12, exp_wrap[i]); end
      checks++; if (at_max12 !== exp_max[i]) begin errors++; $display("FAIL upwrap_atmax[%0d] got %b want %b", i, at_max12, exp_max[i]); end
    end
  endtask

  task automatic test_down_sat();
    sat_mode = 1'b1; en = 1'b0; load = 1'b1; d_in = 4'd1; tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (d_out12 !== 4'd0) begin errors++; $display("FAIL downsat_dout[%0d] got %0d want 0", i, d_out12); end
      checks++; if (wrap12 !== 1'b0 || at_min12 !== 1'b1) begin errors++; $display("FAIL downsat_flags[%0d] got wrap=%b min=%b want 0 1", i, wrap12, at_min12); end
    end
  endtask

  task automatic test_bad_load();
    en = 1'b0; sat_mode = 1'b0; load = 1'b1; d_in = 4'd13; tick();
    checks++; if (d_out12 !== 4'd11 || err12 !== 1'b1) begin errors++; $display("FAIL badload got %0d err=%b want 11 1", d_out12, err12); end
    checks++; if (at_max12 !== 1'b1) begin errors++; $display("FAIL badload_atmax got %b want 1", at_max12); end
    load = 1'b0; tick();
    checks++; if (d_out12 !== 4'd11 || err12 !== 1'b0) begin errors++; $display("FAIL badload_pulse got %0d err=%b want 11 0", d_out12, err12); end
    load = 1'b1; d_in = 4'd5; tick();
    checks++; if (d_out12 !== 4'd5 || err12 !== 1'b0) begin errors++; $display("FAIL goodload got %0d err=%b want 5 0", d_out12, err12); end
    load = 1'b0;
  endtask

  task automatic test_priority();
    en = 1'b0; sat_mode = 1'b0; load = 1'b1; d_in = 4'd11; tick();
    en = 1'b1; up_dn = 1'b1; d_in = 4'd3; tick();
    checks++; if (d_out12 !== 4'd3 || wrap12 !== 1'b0) begin errors++; $display("FAIL priority got %0d wrap=%b want 3 0", d_out12, wrap12); end
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (d_out12 !== 4'd3 || wrap12 !== 1'b0) begin errors++; $display("FAIL hold[%0d] got %0d wrap=%b want 3 0", i, d_out12, wrap12); end
    end
  endtask

  task automatic test_param_sweep();
    int wr16 = 0, wr5 = 0, last16 = -1, last5 = -1;
    reset_now();
    load = 1'b0; en = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      checks++; if (d_out16 !== 4'(m16) || wrap16 !== w16) begin errors++; $display("FAIL sweep16[%0d] got %0d wrap=%b want %0d %b", i, d_out16, wrap16, m16, w16); end
      checks++; if (d_out5 !== 3'(m5) || wrap5 !== w5 || d_out5 >= 3'd5) begin errors++; $display("FAIL sweep5[%0d] got %0d wrap=%b want %0d %b", i, d_out5, wrap5, m5, w5); end
      if (wrap16 === 1'b1) begin
        checks++; if (last16 >= 0 && i - last16 != 16) begin errors++; $display("FAIL sweep16_period got %0d want 16", i - last16); end
        wr16++; last16 = i;
      end
      if (wrap5 === 1'b1) begin
        checks++; if (last5 >= 0 && i - last5 != 5) begin errors++; $display("FAIL sweep5_period got %0d want 5", i - last5); end
        wr5++; last5 = i;
      end
    end
    checks++; if (wr16 != (2 + 32) / 16) begin errors++; $display("FAIL sweep16_wraps got %0d want %0d", wr16, (2 + 32) / 16); end
    checks++; if (wr5 != (2 + 32) / 5) begin errors++; $display("FAIL sweep5_wraps got %0d want %0d", wr5, (2 + 32) / 5); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1);
      sat_mode = ($urandom_range(0, 3) == 0);
      load     = ($urandom_range(0, 7) == 0);
      d_in     = 4'($urandom_range(0, 15));
      tick();
      checks++; if (d_out12 !== 4'(m12)) begin errors++; $display("FAIL rand12_dout[%0d] got %0d want %0d", i, d_out12, m12); end
      checks++; if (wrap12 !== w12 || err12 !== e12) begin errors++; $display("FAIL rand12_pulses[%0d] got wrap=%b err=%b want %b %b", i, wrap12, err12, w12, e12); end
      checks++; if (at_max12 !== (m12 == 11) || at_min12 !== (m12 == 0)) begin errors++; $display("FAIL rand12_flags[%0d] got max=%b min=%b for count %0d", i, at_max12, at_min12, m12); end
      checks++; if (d_out16 !== 4'(m16) || wrap16 !== w16 || err16 !== e16) begin errors++; $display("FAIL rand16[%0d] got %0d w=%b e=%b want %0d %b %b", i, d_out16, wrap16, err16, m16, w16, e16); end
      checks++; if (d_out5 !== 3'(m5) || wrap5 !== w5 || err5 !== e5) begin errors++; $display("FAIL rand5[%0d] got %0d w=%b e=%b want %0d %b %b", i, d_out5, wrap5, err5, m5, w5, e5); end
      checks++; if (at_max5 !== (m5 == 4) || at_min16 !== (m16 == 0)) begin errors++; $display("FAIL rand_flags[%0d] got max5=%b min16=%b", i, at_max5, at_min16); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_bad_load();
    test_priority();
    test_param_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
